// File: rtl/compound_msg_packer_if.sv
// Message type, debug section encoding and the sample/message handshake bundle
// shared by compound_msg_packer and its neighbours.
package compound_msg_pkg;
  typedef struct packed {
    logic               mode;
    logic signed [31:0] x;
    logic               y;
  } compound_type_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    SEC_EMPTY   = 2'd0,
    SEC_PARTIAL = 2'd1,
    SEC_FULL    = 2'd2
  } packer_section_e;
endpackage

interface compound_msg_packer_if;
  import compound_msg_pkg::*;

  logic signed [31:0] data_in;
  logic               mode_in;
  logic               data_in_sync;
  logic               data_in_notify;
  compound_type_t     b_out;
  logic               b_out_sync;
  logic               b_out_notify;

  // packer side
  modport master (
    input  data_in, mode_in, data_in_sync, b_out_sync,
    output data_in_notify, b_out, b_out_notify
  );

  // producer/consumer side
  modport slave (
    output data_in, mode_in, data_in_sync, b_out_sync,
    input  data_in_notify, b_out, b_out_notify
  );
endinterface

// File: rtl/compound_msg_packer.sv
// Packs raw samples into {mode, x, y} messages and buffers them in a DEPTH-entry FIFO.
// Defining COMPOUND_MSG_PACKER_STATS_EN adds the tx_count / stall_count outputs.
module compound_msg_packer
  import compound_msg_pkg::*;
#(
  parameter int                 DEPTH       = 4,
  parameter logic signed [31:0] Y_THRESHOLD = 32'sd0
) (
  input  logic                  clk,
  input  logic                  rst,
  compound_msg_packer_if.master bus,
`ifdef COMPOUND_MSG_PACKER_STATS_EN
  output logic [31:0]           tx_count,
  output logic [31:0]           stall_count,
`endif
  output packer_section_e       section
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam compound_type_t RESET_MSG = '{mode: MODE_READ, x: 32'sd0, y: 1'b0};

  compound_type_t  mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  packer_section_e section_r;
  packer_section_e section_next_s;
  logic            push_s;
  logic            pop_s;

  function automatic compound_type_t pack_msg(input logic signed [31:0] data, input logic mode);
    compound_type_t msg;
    msg.mode = mode ? MODE_WRITE : MODE_READ;
    msg.x    = data;
    msg.y    = (data > Y_THRESHOLD);
    return msg;
  endfunction

  assign push_s = bus.data_in_sync && bus.data_in_notify;
  assign pop_s  = bus.b_out_sync && bus.b_out_notify;

  // Occupancy after this cycle's handshakes.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + COUNT_ONE;
      2'b01:   count_next_s = count_r - COUNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_MSG;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= COUNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pack_msg(bus.data_in, bus.mode_in);
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Section state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      section_r <= SEC_EMPTY;
    end else begin
      section_r <= section_next_s;
    end
  end

  // Section follows the updated occupancy.
  always_comb begin
    section_next_s = SEC_PARTIAL;
    if (count_next_s == COUNT_ZERO) begin
      section_next_s = SEC_EMPTY;
    end else if (count_next_s == COUNT_FULL) begin
      section_next_s = SEC_FULL;
    end else begin
      section_next_s = SEC_PARTIAL;
    end
  end

  // Handshake outputs; section mirrors count, so notifies move the cycle after the change.
  always_comb begin
    bus.data_in_notify = 1'b1;
    bus.b_out_notify   = 1'b0;
    case (section_r)
      SEC_EMPTY: begin
        bus.data_in_notify = 1'b1;
        bus.b_out_notify   = 1'b0;
      end
      SEC_FULL: begin
        bus.data_in_notify = 1'b0;
        bus.b_out_notify   = 1'b1;
      end
      default: begin
        bus.data_in_notify = 1'b1;
        bus.b_out_notify   = 1'b1;
      end
    endcase
  end

  assign bus.b_out = mem_r[rd_ptr_r];
  assign section   = section_r;

`ifdef COMPOUND_MSG_PACKER_STATS_EN
  logic [31:0] tx_count_r;
  logic [31:0] stall_count_r;

  // Pop and stall counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_count_r    <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (pop_s) begin
        tx_count_r <= tx_count_r + 32'd1;
      end
      if (bus.data_in_sync && !bus.data_in_notify) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
    end
  end

  assign tx_count    = tx_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_compound_msg_packer.sv
// Self-checking bench for compound_msg_packer: directed steps followed by random traffic,
// checked against a queue-based reference model.
module tb_compound_msg_packer;
  import compound_msg_pkg::*;

  localparam int DEPTH       = 4;
  localparam int Y_THRESHOLD = 0;

  logic clk;
  logic rst;
  packer_section_e section;
`ifdef COMPOUND_MSG_PACKER_STATS_EN
  logic [31:0] tx_count;
  logic [31:0] stall_count;
  int unsigned exp_tx;
  int unsigned exp_stall;
`endif

  int compared;
  int mismatched;
  bit model_valid;
  compound_type_t q[$];

  compound_msg_packer_if bus ();

  compound_msg_packer #(
    .DEPTH       (DEPTH),
    .Y_THRESHOLD (32'sd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef COMPOUND_MSG_PACKER_STATS_EN
    .tx_count    (tx_count),
    .stall_count (stall_count),
`endif
    .section     (section)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic compound_type_t mk(input int d, input logic m);
    compound_type_t r;
    r.mode = m;
    r.x    = d;
    r.y    = (d > Y_THRESHOLD) ? 1'b1 : 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the negedge, check against the model, then commit the model.
  task automatic cycle(input logic r, input logic isync, input int d, input logic m, input logic osync);
    bit do_push;
    bit do_pop;
    logic [1:0] exp_sec;
    rst              = r;
    bus.data_in      = d;
    bus.mode_in      = m;
    bus.data_in_sync = isync;
    bus.b_out_sync   = osync;
    #1;
    if (model_valid) begin
      exp_sec = (q.size() == 0) ? 2'd0 : ((q.size() == DEPTH) ? 2'd2 : 2'd1);
      check("data_in_notify", {63'd0, bus.data_in_notify}, {63'd0, q.size() < DEPTH});
      check("b_out_notify", {63'd0, bus.b_out_notify}, {63'd0, q.size() > 0});
      check("section", {62'd0, section}, {62'd0, exp_sec});
      if (q.size() > 0) check("b_out", {30'd0, bus.b_out}, {30'd0, q[0]});
`ifdef COMPOUND_MSG_PACKER_STATS_EN
      check("tx_count", {32'd0, tx_count}, {32'd0, exp_tx});
      check("stall_count", {32'd0, stall_count}, {32'd0, exp_stall});
`endif
    end
    do_push = r && isync && (q.size() < DEPTH);
    do_pop  = r && osync && (q.size() > 0);
`ifdef COMPOUND_MSG_PACKER_STATS_EN
    if (!r) begin
      exp_tx    = 0;
      exp_stall = 0;
    end else begin
      if (do_pop) exp_tx++;
      if (isync && q.size() == DEPTH) exp_stall++;
    end
`endif
    @(posedge clk);
    if (!r) begin
      q.delete();
      model_valid = 1'b1;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(mk(d, m));
    end
    @(negedge clk);
  endtask

  logic rv;
  logic iv;
  logic ov;
  logic mv;
  int   dv;

  initial begin
    compared    = 0;
    mismatched  = 0;
    model_valid = 1'b0;
`ifdef COMPOUND_MSG_PACKER_STATS_EN
    exp_tx    = 0;
    exp_stall = 0;
`endif
    rst = 1'b0;
    bus.data_in = 32'sd0;
    bus.mode_in = 1'b0;
    bus.data_in_sync = 1'b0;
    bus.b_out_sync = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a producer trying to push.
    cycle(1'b0, 1'b1, 7, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 7, 1'b1, 1'b0);
    rst = 1'b1;
    bus.data_in_sync = 1'b0;
    #1;
    check("rst_b_out", {30'd0, bus.b_out}, 64'd0);
    check("rst_b_out_notify", {63'd0, bus.b_out_notify}, 64'd0);
    check("rst_data_in_notify", {63'd0, bus.data_in_notify}, 64'd1);

    // Single transfer.
    cycle(1'b1, 1'b1, 5, 1'b1, 1'b0);
    check("single_b_out", {30'd0, bus.b_out}, {30'd0, 1'b1, 32'd5, 1'b1});
    check("single_notify", {63'd0, bus.b_out_notify}, 64'd1);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Threshold boundary: 0, -1, 1.
    cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, -1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Fill, blocked fifth push, partial drain and wrap.
    for (int i = 10; i < 14; i++) cycle(1'b1, 1'b1, i, 1'b1, 1'b0);
    check("full_data_in_notify", {63'd0, bus.data_in_notify}, 64'd0);
    cycle(1'b1, 1'b1, 99, 1'b1, 1'b0);
`ifdef COMPOUND_MSG_PACKER_STATS_EN
    check("stall_after_fill", {32'd0, stall_count}, 64'd1);
`endif
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 14, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 15, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Concurrent traffic at count 2.
    cycle(1'b1, 1'b1, 100, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 101, 1'b0, 1'b0);
    for (int i = 102; i < 110; i++) cycle(1'b1, 1'b1, i, i[0], 1'b1);
    check("concurrent_section", {62'd0, section}, {62'd0, SEC_PARTIAL});
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Mid-operation reset with three messages buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 50 + i, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("midrst_notify", {63'd0, bus.b_out_notify}, 64'd0);
    cycle(1'b1, 1'b1, 99, 1'b0, 1'b0);
    check("midrst_x", {32'd0, bus.b_out.x}, 64'd99);
    check("midrst_y", {63'd0, bus.b_out.y}, 64'd1);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 63) != 0);
      iv = ($urandom_range(0, 2) != 0);
      ov = ($urandom_range(0, 2) != 0);
      mv = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) dv = int'($urandom_range(0, 4)) - 2;
      else dv = int'($urandom);
      cycle(rv, iv, dv, mv, ov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
